// File: rtl/rv_plic_claim_ctrl.sv
// Per-target PLIC claim/complete controller: it arbitrates the pending sources,
// drives the target interrupt, and returns one-hot claim/complete pulses to the gateways.
module rv_plic_claim_ctrl #(
   parameter int N_SOURCE = 32,
   parameter int PRIO_W   = 2,
   parameter int ID_W     = $clog2(N_SOURCE)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [N_SOURCE-1:0]        ip_i,
   input  logic [N_SOURCE-1:0]        ie_i,
   input  logic [N_SOURCE*PRIO_W-1:0] prio_i,
   input  logic [PRIO_W-1:0]          threshold_i,
   input  logic                       claim_req_i,
   output logic                       claim_ack_o,
   output logic [ID_W-1:0]            claim_id_o,
   input  logic                       complete_we_i,
   input  logic [ID_W-1:0]            complete_id_i,
   output logic [N_SOURCE-1:0]        claim_o,
   output logic [N_SOURCE-1:0]        complete_o,
   output logic                       irq_o,
   output logic [ID_W-1:0]            irq_id_o
);

   typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

   localparam logic [N_SOURCE-1:0] ONE_HOT_BASE = {{(N_SOURCE-1){1'b0}}, 1'b1};

   state_t              r_state;
   state_t              w_nextState;
   logic [ID_W-1:0]     r_claimed;
   logic                r_irq;
   logic [ID_W-1:0]     r_irqId;
   logic [N_SOURCE-1:0] r_complete;
   logic [ID_W-1:0]     w_winId;
   logic [PRIO_W-1:0]   w_winPrio;
   logic                w_completeValid;
   logic                w_unusedBits;

   // Source 0 is reserved, so its pending, enable and priority bits are never looked at.
   assign w_unusedBits = ^{ip_i[0], ie_i[0], prio_i[PRIO_W-1:0]};

   // Strict '>' on priority keeps the lowest ID on a tie; the captured ID is masked until IDLE.
   always_comb begin
      w_winId   = '0;
      w_winPrio = '0;
      for (int i = 1; i < N_SOURCE; i++) begin
         if (ip_i[i] && ie_i[i]
             && (prio_i[i*PRIO_W +: PRIO_W] > threshold_i)
             && !((r_state != S_IDLE) && (r_claimed == ID_W'(i)))
             && (prio_i[i*PRIO_W +: PRIO_W] > w_winPrio)) begin
            w_winPrio = prio_i[i*PRIO_W +: PRIO_W];
            w_winId   = ID_W'(i);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_irq   <= 1'b0;
         r_irqId <= '0;
      end else begin
         r_irq   <= (w_winId != '0);
         r_irqId <= w_winId;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_claimed <= '0;
      end else if ((r_state == S_IDLE) && claim_req_i) begin
         r_claimed <= r_irqId;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (claim_req_i) w_nextState = S_ACK;
         S_ACK:   w_nextState = S_WAIT;
         S_WAIT:  w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   always_comb begin
      claim_ack_o = 1'b0;
      claim_id_o  = '0;
      claim_o     = '0;
      if (r_state == S_ACK) begin
         claim_ack_o = 1'b1;
         claim_id_o  = r_claimed;
         if (r_claimed != '0) begin
            claim_o = ONE_HOT_BASE << r_claimed;
         end
      end
   end

   // Completion runs beside the claim FSM; out-of-range IDs vanish without a pulse.
   assign w_completeValid = complete_we_i && (complete_id_i != '0)
                            && (32'(complete_id_i) < 32'(N_SOURCE));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_complete <= '0;
      end else if (w_completeValid) begin
         r_complete <= ONE_HOT_BASE << complete_id_i;
      end else begin
         r_complete <= '0;
      end
   end

   assign irq_o      = r_irq;
   assign irq_id_o   = r_irqId;
   assign complete_o = r_complete;

endmodule

// File: tb/tb_rv_plic_claim_ctrl.sv
// Bench for rv_plic_claim_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a priority-scan reference model.
module tb_rv_plic_claim_ctrl;

   localparam int NS = 32;
   localparam int PW = 2;
   localparam int IW = 6;

   logic             clk = 1'b0;
   logic             rst_ni = 1'b0;
   logic [NS-1:0]    ip_i = '0;
   logic [NS-1:0]    ie_i = '0;
   logic [NS*PW-1:0] prio_i = '0;
   logic [PW-1:0]    threshold_i = '0;
   logic             claim_req_i = 1'b0;
   logic             claim_ack_o;
   logic [IW-1:0]    claim_id_o;
   logic             complete_we_i = 1'b0;
   logic [IW-1:0]    complete_id_i = '0;
   logic [NS-1:0]    claim_o;
   logic [NS-1:0]    complete_o;
   logic             irq_o;
   logic [IW-1:0]    irq_id_o;

   int errCnt = 0;
   int checkCnt = 0;
   bit checksOn = 1'b0;

   logic [NS-1:0] gwClear = '0;
   logic          ackSeen = 1'b0;

   int mIrq = 0;
   int mIrqId = 0;
   int mPhase = 0;
   int mClaimed = 0;
   logic [NS-1:0] mComplete = '0;

   rv_plic_claim_ctrl #(.N_SOURCE(NS), .PRIO_W(PW), .ID_W(IW)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .ip_i(ip_i), .ie_i(ie_i), .prio_i(prio_i),
      .threshold_i(threshold_i), .claim_req_i(claim_req_i), .claim_ack_o(claim_ack_o),
      .claim_id_o(claim_id_o), .complete_we_i(complete_we_i), .complete_id_i(complete_id_i),
      .claim_o(claim_o), .complete_o(complete_o), .irq_o(irq_o), .irq_id_o(irq_id_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCnt++;
      if (act !== exp) begin
         errCnt++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Walk priority levels from highest down, IDs upward within a level.
   function automatic int refWinner(input logic [NS-1:0] ip, input logic [NS-1:0] ie,
                                    input logic [NS*PW-1:0] pr, input logic [PW-1:0] thr,
                                    input int excl);
      for (int p = (1 << PW) - 1; p > int'(thr); p--)
         for (int id = 1; id < NS; id++)
            if (ip[id] && ie[id] && int'(pr[id*PW +: PW]) == p && id != excl) return id;
      return 0;
   endfunction

   always @(posedge clk or negedge rst_ni) begin
      int win;
      if (!rst_ni) begin
         mIrq = 0; mIrqId = 0; mPhase = 0; mClaimed = 0; mComplete = '0;
      end else begin
         win = refWinner(ip_i, ie_i, prio_i, threshold_i, (mPhase != 0) ? mClaimed : -1);
         if (mPhase == 0 && claim_req_i) begin
            mClaimed = mIrqId;
            mPhase = 1;
         end else if (mPhase == 1) mPhase = 2;
         else mPhase = 0;
         mComplete = '0;
         if (complete_we_i && int'(complete_id_i) >= 1 && int'(complete_id_i) < NS)
            mComplete[int'(complete_id_i)] = 1'b1;
         mIrqId = win;
         mIrq = (win != 0) ? 1 : 0;
      end
   end

   always @(negedge clk) begin
      gwClear <= claim_o;
      ackSeen <= claim_ack_o;
   end

   always @(negedge clk) begin
      logic [NS-1:0] expClaim;
      if (checksOn) begin
         expClaim = '0;
         if (mPhase == 1 && mClaimed != 0) expClaim[mClaimed] = 1'b1;
         checkOutput("model_irq", 64'(irq_o), 64'(mIrq));
         checkOutput("model_irq_id", 64'(irq_id_o), 64'(mIrqId));
         checkOutput("model_ack", 64'(claim_ack_o), 64'(mPhase == 1));
         checkOutput("model_claim_id", 64'(claim_id_o), (mPhase == 1) ? 64'(mClaimed) : 64'd0);
         checkOutput("model_claim_o", 64'(claim_o), 64'(expClaim));
         checkOutput("model_complete_o", 64'(complete_o), 64'(mComplete));
      end
   end

   // Advance one cycle; the emulated gateway drops ip for whatever was just claimed.
   task automatic nextCycle();
      @(posedge clk);
      #2;
      ip_i = ip_i & ~gwClear;
   endtask

   task automatic applyStimulus();
      int idx;
      nextCycle();
      if ($urandom_range(0, 5) == 0) begin
         idx = $urandom_range(0, NS - 1);
         ip_i[idx] = 1'b1;
      end
      if ($urandom_range(0, 63) == 0) ie_i = $urandom | $urandom;
      if ($urandom_range(0, 15) == 0) begin
         idx = $urandom_range(0, NS - 1);
         prio_i[idx*PW +: PW] = PW'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 49) == 0) threshold_i = PW'($urandom_range(0, 3));
      if (claim_req_i && ackSeen) claim_req_i = 1'($urandom_range(0, 1));
      else if (!claim_req_i) claim_req_i = ($urandom_range(0, 3) == 0);
      complete_we_i = ($urandom_range(0, 3) == 0);
      complete_id_i = IW'($urandom_range(0, 63));
   endtask

   initial begin
      ie_i = '1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_irq", 64'(irq_o), 64'd0);
      checkOutput("reset_irq_id", 64'(irq_id_o), 64'd0);
      checkOutput("reset_ack", 64'(claim_ack_o), 64'd0);
      checkOutput("reset_claim_o", 64'(claim_o), 64'd0);
      checkOutput("reset_complete_o", 64'(complete_o), 64'd0);
      checksOn = 1'b1;
      nextCycle();
      rst_ni = 1'b1;

      // Prioritised claim
      nextCycle();
      prio_i = '0; prio_i[3*PW +: PW] = 2'd2; prio_i[5*PW +: PW] = 2'd3;
      ip_i = '0; ip_i[3] = 1'b1; ip_i[5] = 1'b1;
      nextCycle();
      claim_req_i = 1'b1;
      @(negedge clk);
      checkOutput("prio_irq_id", 64'(irq_id_o), 64'd5);
      nextCycle();
      claim_req_i = 1'b0;
      @(negedge clk);
      checkOutput("prio_ack", 64'(claim_ack_o), 64'd1);
      checkOutput("prio_claim_id", 64'(claim_id_o), 64'd5);
      checkOutput("prio_claim_o", 64'(claim_o), 64'h20);
      nextCycle();
      @(negedge clk);
      checkOutput("prio_wait_irq_id", 64'(irq_id_o), 64'd3);
      nextCycle();

      // Tie and threshold
      nextCycle();
      prio_i = '0; prio_i[2*PW +: PW] = 2'd1; prio_i[7*PW +: PW] = 2'd1;
      threshold_i = 2'd1;
      ip_i = '0; ip_i[2] = 1'b1; ip_i[7] = 1'b1;
      nextCycle();
      @(negedge clk);
      checkOutput("thr_irq_low", 64'(irq_o), 64'd0);
      nextCycle();
      threshold_i = 2'd0;
      nextCycle();
      @(negedge clk);
      checkOutput("tie_irq", 64'(irq_o), 64'd1);
      checkOutput("tie_irq_id", 64'(irq_id_o), 64'd2);

      // Empty claim
      nextCycle();
      ip_i = '0;
      nextCycle();
      claim_req_i = 1'b1;
      nextCycle();
      claim_req_i = 1'b0;
      @(negedge clk);
      checkOutput("empty_ack", 64'(claim_ack_o), 64'd1);
      checkOutput("empty_claim_id", 64'(claim_id_o), 64'd0);
      checkOutput("empty_claim_o", 64'(claim_o), 64'd0);
      nextCycle();
      nextCycle();

      // Complete decode
      nextCycle();
      complete_we_i = 1'b1; complete_id_i = 6'd4;
      nextCycle();
      complete_id_i = 6'd0;
      @(negedge clk);
      checkOutput("cpl_id4", 64'(complete_o), 64'h10);
      nextCycle();
      complete_id_i = 6'd40;
      @(negedge clk);
      checkOutput("cpl_id0", 64'(complete_o), 64'd0);
      nextCycle();
      complete_we_i = 1'b0;
      @(negedge clk);
      checkOutput("cpl_id40", 64'(complete_o), 64'd0);

      // Concurrency: held request, complete in the ACK cycle
      nextCycle();
      prio_i = '0; prio_i[1*PW +: PW] = 2'd1; prio_i[6*PW +: PW] = 2'd3;
      ip_i = '0; ip_i[1] = 1'b1; ip_i[6] = 1'b1;
      nextCycle();
      claim_req_i = 1'b1;
      nextCycle();
      complete_we_i = 1'b1; complete_id_i = 6'd6;
      @(negedge clk);
      checkOutput("conc_ack1", 64'(claim_ack_o), 64'd1);
      checkOutput("conc_id1", 64'(claim_id_o), 64'd6);
      nextCycle();
      complete_we_i = 1'b0;
      @(negedge clk);
      checkOutput("conc_cpl6", 64'(complete_o), 64'h40);
      checkOutput("conc_wait_ack", 64'(claim_ack_o), 64'd0);
      nextCycle();
      @(negedge clk);
      checkOutput("conc_idle_ack", 64'(claim_ack_o), 64'd0);
      checkOutput("conc_idle_cpl", 64'(complete_o), 64'd0);
      nextCycle();
      claim_req_i = 1'b0;
      @(negedge clk);
      checkOutput("conc_ack2", 64'(claim_ack_o), 64'd1);
      checkOutput("conc_id2", 64'(claim_id_o), 64'd1);
      checkOutput("conc_claim_o2", 64'(claim_o), 64'h2);
      nextCycle();
      nextCycle();

      // Reset dropped in ACK with a complete pending
      nextCycle();
      prio_i = '0; prio_i[3*PW +: PW] = 2'd2;
      ip_i = '0; ip_i[3] = 1'b1;
      nextCycle();
      claim_req_i = 1'b1;
      nextCycle();
      claim_req_i = 1'b0;
      complete_we_i = 1'b1; complete_id_i = 6'd3;
      #1;
      checkOutput("rstmid_pre_ack", 64'(claim_ack_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      checkOutput("rstmid_ack", 64'(claim_ack_o), 64'd0);
      checkOutput("rstmid_claim_id", 64'(claim_id_o), 64'd0);
      checkOutput("rstmid_claim_o", 64'(claim_o), 64'd0);
      checkOutput("rstmid_irq", 64'(irq_o), 64'd0);
      checkOutput("rstmid_irq_id", 64'(irq_id_o), 64'd0);
      complete_we_i = 1'b0;
      nextCycle();
      nextCycle();
      rst_ni = 1'b1;
      @(negedge clk);
      checkOutput("rstrel_claim_o", 64'(claim_o), 64'd0);
      checkOutput("rstrel_complete_o", 64'(complete_o), 64'd0);
      nextCycle();
      @(negedge clk);
      checkOutput("rstrel2_claim_o", 64'(claim_o), 64'd0);
      checkOutput("rstrel2_complete_o", 64'(complete_o), 64'd0);

      // Randomized traffic against the reference model
      ie_i = $urandom | $urandom;
      prio_i = {$urandom, $urandom};
      for (int c = 0; c < 2000; c++) applyStimulus();
      nextCycle();
      claim_req_i = 1'b0;
      complete_we_i = 1'b0;
      repeat (4) nextCycle();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
      $finish;
   end

endmodule
